// File: rtl/ram2_arb_pkg.sv
// Shared types and constants for the RAM2 access arbiter.
//   state_e  : access sequence IDLE -> SETUP -> STROBE -> DONE
//   port_e   : requester identity (data port or fetch port)
//   access_t : access latched at grant time
package ram2_arb_pkg;

   localparam int unsigned RAM2_ADDR_W = 18;
   localparam int unsigned DATA_W      = 16;
   localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef enum logic {
      PORT_MEM = 1'b0,
      PORT_IF  = 1'b1
   } port_e;

   typedef struct packed {
      port_e                  port;
      logic                   we;
      logic [RAM2_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]      wdata;
   } access_t;

   // Request-mask bit for a port: bit 0 = mem, bit 1 = if.
   function automatic logic [1:0] port_mask(input port_e p);
      return (p == PORT_IF) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram2_access_arbiter_if.sv
// Pipeline-side request/response bus of the RAM2 arbiter.
//   if_*  : fetch port (read only)
//   mem_* : data port (read/write)
//   busy  : arbiter is in an access sequence
// Modports: master = pipeline side, slave = arbiter side.
interface ram2_access_arbiter_if
   import ram2_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_instr;
   logic              if_valid;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;
   logic              busy;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
      input  if_instr, if_valid, mem_rdata, mem_valid, busy
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
      output if_instr, if_valid, mem_rdata, mem_valid, busy
   );
endinterface

// File: rtl/ram2_arb_grant.sv
// Combinational winner select between the fetch and data ports.
// Ports:
//   i_if_req, i_mem_req : raw requests
//   i_excl              : ports excluded this cycle (bit 0 mem, bit 1 if)
//   i_rr_if_next        : on a tie, 1 = fetch port wins (round-robin build)
//   o_gnt_vld           : some eligible request present
//   o_gnt_port          : winning port
//   o_tie               : both ports eligible
// Build option: RAM2_RR_PRIORITY_EN selects round-robin tie breaking;
// otherwise the data port always wins a tie.
module ram2_arb_grant
   import ram2_arb_pkg::*;
(
   input  logic       i_if_req,
   input  logic       i_mem_req,
   input  logic [1:0] i_excl,
   input  logic       i_rr_if_next,
   output logic       o_gnt_vld,
   output port_e      o_gnt_port,
   output logic       o_tie
);

   logic w_mem_ok;
   logic w_if_ok;

   always_comb begin
      w_mem_ok   = i_mem_req & ~i_excl[0];
      w_if_ok    = i_if_req  & ~i_excl[1];
      o_gnt_vld  = w_mem_ok | w_if_ok;
      o_tie      = w_mem_ok & w_if_ok;
`ifdef RAM2_RR_PRIORITY_EN
      if (o_tie) begin
         o_gnt_port = i_rr_if_next ? PORT_IF : PORT_MEM;
      end else begin
         o_gnt_port = w_mem_ok ? PORT_MEM : PORT_IF;
      end
`else
      o_gnt_port = w_mem_ok ? PORT_MEM : PORT_IF;
`endif
   end

`ifndef RAM2_RR_PRIORITY_EN
   // Tie-break state is irrelevant with fixed priority.
   logic w_unused_rr;
   assign w_unused_rr = i_rr_if_next;
`endif

endmodule

// File: rtl/ram2_access_arbiter.sv
// Shares the external RAM2 SRAM between the fetch port and the data port.
// Each access runs IDLE -> SETUP -> STROBE -> DONE; the served port gets a
// one-cycle valid pulse in DONE. All outputs except the RAM2DATA tristate
// are registered.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   bus (slave)         : fetch/data request-response bus, plus busy
//   RAM2EN/OE/WE        : active-low SRAM strobes
//   RAM2ADDR            : SRAM address (zero-extended requester address)
//   RAM2DATA            : SRAM data, driven only for writes (SETUP..DONE)
// Build option: RAM2_RR_PRIORITY_EN (round-robin tie breaking in IDLE).
module ram2_access_arbiter
   import ram2_arb_pkg::*;
#(
   parameter int unsigned       ADDR_W = 16,
   parameter logic [DATA_W-1:0] NOP    = NOP_INSTR
)
(
   input  logic                   CLK,
   input  logic                   RST,
   ram2_access_arbiter_if.slave   bus,
   output logic                   RAM2EN,
   output logic                   RAM2OE,
   output logic                   RAM2WE,
   output logic [RAM2_ADDR_W-1:0] RAM2ADDR,
   inout  wire  [DATA_W-1:0]      RAM2DATA
);

   state_e            r_state;
   state_e            w_next;
   access_t           r_acc;
   access_t           w_acc;
   access_t           w_new_acc;
   logic              r_en_n, r_oe_n, r_we_n, r_drive;
   logic              w_en_n, w_oe_n, w_we_n, w_drive;
   logic              r_if_valid, r_mem_valid, r_busy;
   logic              w_if_valid, w_mem_valid;
   logic [DATA_W-1:0] r_if_instr, r_mem_rdata;
   logic              w_capture;
   logic              w_load;
   logic              r_rr_if_next, w_rr_if_next;
   logic [1:0]        w_excl;
   logic              w_gnt_vld;
   port_e             w_gnt_port;
   logic              w_tie;
   logic [ADDR_W-1:0] w_if_addr;
   logic [ADDR_W-1:0] w_mem_addr;

   assign w_if_addr  = bus.if_addr;
   assign w_mem_addr = bus.mem_addr;

   // The port served in DONE still holds req this cycle; keep it out of re-arbitration.
   assign w_excl = (r_state == ST_DONE) ? port_mask(r_acc.port) : 2'b00;

   ram2_arb_grant u_grant (
      .i_if_req     (bus.if_req),
      .i_mem_req    (bus.mem_req),
      .i_excl       (w_excl),
      .i_rr_if_next (r_rr_if_next),
      .o_gnt_vld    (w_gnt_vld),
      .o_gnt_port   (w_gnt_port),
      .o_tie        (w_tie)
   );

   // Access descriptor for the winning port.
   always_comb begin
      w_new_acc      = '0;
      w_new_acc.port = w_gnt_port;
      if (w_gnt_port == PORT_MEM) begin
         w_new_acc.we    = bus.mem_we;
         w_new_acc.addr  = RAM2_ADDR_W'(w_mem_addr);
         w_new_acc.wdata = bus.mem_wdata;
      end else begin
         w_new_acc.we    = 1'b0;
         w_new_acc.addr  = RAM2_ADDR_W'(w_if_addr);
         w_new_acc.wdata = '0;
      end
   end

   // Next state and next values of the registered pin/response outputs.
   always_comb begin
      w_next       = r_state;
      w_acc        = r_acc;
      w_en_n       = 1'b1;
      w_oe_n       = 1'b1;
      w_we_n       = 1'b1;
      w_drive      = 1'b0;
      w_if_valid   = 1'b0;
      w_mem_valid  = 1'b0;
      w_capture    = 1'b0;
      w_load       = 1'b0;
      w_rr_if_next = r_rr_if_next;

      unique case (r_state)
         ST_IDLE: begin
            w_load = w_gnt_vld;
         end
         ST_SETUP: begin
            w_next  = ST_STROBE;
            w_en_n  = 1'b0;
            w_oe_n  = r_acc.we;
            w_we_n  = ~r_acc.we;
            w_drive = r_acc.we;
         end
         ST_STROBE: begin
            w_next      = ST_DONE;
            w_capture   = ~r_acc.we;
            w_drive     = r_acc.we;
            w_if_valid  = (r_acc.port == PORT_IF);
            w_mem_valid = (r_acc.port == PORT_MEM);
         end
         ST_DONE: begin
            w_load = w_gnt_vld;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase

      if (w_load) begin
         w_next  = ST_SETUP;
         w_acc   = w_new_acc;
         w_en_n  = 1'b0;
         w_drive = w_new_acc.we;
         // Loser of this tie is favoured on the next one.
         if (w_tie) begin
            w_rr_if_next = (w_gnt_port == PORT_MEM);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_acc        <= '0;
         r_en_n       <= 1'b1;
         r_oe_n       <= 1'b1;
         r_we_n       <= 1'b1;
         r_drive      <= 1'b0;
         r_if_valid   <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_if_instr   <= NOP;
         r_mem_rdata  <= '0;
         r_rr_if_next <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_acc        <= w_acc;
         r_en_n       <= w_en_n;
         r_oe_n       <= w_oe_n;
         r_we_n       <= w_we_n;
         r_drive      <= w_drive;
         r_if_valid   <= w_if_valid;
         r_mem_valid  <= w_mem_valid;
         r_busy       <= (w_next != ST_IDLE);
         r_rr_if_next <= w_rr_if_next;
         // Read data is sampled at the edge that closes STROBE.
         if (w_capture) begin
            if (r_acc.port == PORT_IF) begin
               r_if_instr <= RAM2DATA;
            end else begin
               r_mem_rdata <= RAM2DATA;
            end
         end
      end
   end

   assign RAM2EN        = r_en_n;
   assign RAM2OE        = r_oe_n;
   assign RAM2WE        = r_we_n;
   assign RAM2ADDR      = r_acc.addr;
   assign RAM2DATA      = r_drive ? r_acc.wdata : {DATA_W{1'bz}};

   assign bus.if_instr  = r_if_instr;
   assign bus.if_valid  = r_if_valid;
   assign bus.mem_rdata = r_mem_rdata;
   assign bus.mem_valid = r_mem_valid;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_ram2_access_arbiter.sv
// Self-checking bench for ram2_access_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized two-port phase
// checked against a transaction-level memory model.
module tb_ram2_access_arbiter;
   import ram2_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ram2en, ram2oe, ram2we;
   logic [17:0] ram2addr;
   wire  [15:0] ram2data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram2_access_arbiter_if #(.ADDR_W(16)) bus ();

   ram2_access_arbiter #(.ADDR_W(16), .NOP(16'h0800)) dut (
      .CLK      (clk),
      .RST      (rst),
      .bus      (bus),
      .RAM2EN   (ram2en),
      .RAM2OE   (ram2oe),
      .RAM2WE   (ram2we),
      .RAM2ADDR (ram2addr),
      .RAM2DATA (ram2data)
   );

   // Asynchronous SRAM model (64K words used).
   logic [15:0] sram [0:65535];
   assign ram2data = (!ram2en && !ram2oe) ? sram[ram2addr[15:0]] : 16'hzzzz;
   always @(posedge clk) begin
      if (!ram2en && !ram2we) sram[ram2addr[15:0]] <= ram2data;
   end

   // Reference memory contents as seen by requesters.
   logic [15:0] model_mem [logic [15:0]];
   logic [15:0] last_mem_rd;

   function automatic logic [15:0] model_rd(input logic [15:0] a);
      return model_mem.exists(a) ? model_mem[a] : (a ^ 16'h5A5A);
   endfunction

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: at most one valid pulse, never OE and WE low together.
   always @(negedge clk) begin
      if (!rst) begin
         chk_b("one_valid", bus.if_valid & bus.mem_valid, 1'b0);
         chk_b("oe_we_excl", ~ram2oe & ~ram2we, 1'b0);
      end
   end

   typedef struct {
      logic        is_mem;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   // Single isolated access from IDLE, checked cycle by cycle.
   task automatic run_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d_", idx);
      if (v.is_mem) begin
         bus.mem_req = 1'b1; bus.mem_we = v.we; bus.mem_addr = v.addr; bus.mem_wdata = v.wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      @(negedge clk); // SETUP
      chk_b({p, "setup_en"}, ram2en, 1'b0);
      chk_b({p, "setup_oe"}, ram2oe, 1'b1);
      chk_b({p, "setup_we"}, ram2we, 1'b1);
      chk_b({p, "setup_busy"}, bus.busy, 1'b1);
      chk_w({p, "setup_addr"}, ram2addr, {2'b00, v.addr});
      if (v.we) chk_w({p, "setup_data"}, 18'(ram2data), 18'(v.wdata));
      @(negedge clk); // STROBE
      chk_b({p, "strobe_en"}, ram2en, 1'b0);
      chk_b({p, "strobe_oe"}, ram2oe, v.we);
      chk_b({p, "strobe_we"}, ram2we, ~v.we);
      chk_b({p, "strobe_noval"}, bus.if_valid | bus.mem_valid, 1'b0);
      if (v.we) chk_w({p, "strobe_data"}, 18'(ram2data), 18'(v.wdata));
      @(negedge clk); // DONE
      chk_b({p, "done_en"}, ram2en, 1'b1);
      chk_b({p, "done_oe"}, ram2oe, 1'b1);
      chk_b({p, "done_we"}, ram2we, 1'b1);
      chk_b({p, "done_if_valid"}, bus.if_valid, ~v.is_mem);
      chk_b({p, "done_mem_valid"}, bus.mem_valid, v.is_mem);
      if (v.we) begin
         chk_w({p, "done_data"}, 18'(ram2data), 18'(v.wdata));
         chk_w({p, "wr_rdata_hold"}, 18'(bus.mem_rdata), 18'(last_mem_rd));
         model_mem[v.addr] = v.wdata;
      end else if (v.is_mem) begin
         chk_w({p, "mem_rdata"}, 18'(bus.mem_rdata), 18'(v.exp_rd));
         last_mem_rd = v.exp_rd;
      end else begin
         chk_w({p, "if_instr"}, 18'(bus.if_instr), 18'(v.exp_rd));
      end
      bus.mem_req = 1'b0;
      bus.if_req  = 1'b0;
      @(negedge clk); // back to IDLE
      chk_b({p, "idle_busy"}, bus.busy, 1'b0);
      chk_b({p, "idle_en"}, ram2en, 1'b1);
      chk_b({p, "idle_valid"}, bus.if_valid | bus.mem_valid, 1'b0);
   endtask

   // Both ports request together from IDLE; first winner's address is checked in SETUP,
   // then each port is released after its own valid pulse.
   task automatic tie_pair(input string p, input logic [15:0] ia, input logic [15:0] ma,
                           input logic exp_if_first);
      logic if_done, mem_done;
      if_done = 1'b0; mem_done = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = ia;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = ma;
      @(negedge clk);
      chk_w({p, "first_addr"}, ram2addr, {2'b00, exp_if_first ? ia : ma});
      @(negedge clk);
      @(negedge clk); // first DONE
      chk_b({p, "first_if_valid"}, bus.if_valid, exp_if_first);
      chk_b({p, "first_mem_valid"}, bus.mem_valid, ~exp_if_first);
      if (bus.if_valid) begin
         chk_w({p, "if_instr"}, 18'(bus.if_instr), 18'(model_rd(ia)));
         bus.if_req = 1'b0; if_done = 1'b1;
      end
      if (bus.mem_valid) begin
         chk_w({p, "mem_rdata"}, 18'(bus.mem_rdata), 18'(model_rd(ma)));
         last_mem_rd = model_rd(ma);
         bus.mem_req = 1'b0; mem_done = 1'b1;
      end
      @(negedge clk); // second port goes straight to SETUP
      chk_b({p, "b2b_busy"}, bus.busy, 1'b1);
      chk_b({p, "b2b_en"}, ram2en, 1'b0);
      chk_w({p, "second_addr"}, ram2addr, {2'b00, exp_if_first ? ma : ia});
      @(negedge clk);
      @(negedge clk); // second DONE, three cycles after the first
      chk_b({p, "second_if_valid"}, bus.if_valid, ~if_done);
      chk_b({p, "second_mem_valid"}, bus.mem_valid, ~mem_done);
      if (!if_done) chk_w({p, "if_instr2"}, 18'(bus.if_instr), 18'(model_rd(ia)));
      if (!mem_done) begin
         chk_w({p, "mem_rdata2"}, 18'(bus.mem_rdata), 18'(model_rd(ma)));
         last_mem_rd = model_rd(ma);
      end
      bus.if_req = 1'b0; bus.mem_req = 1'b0;
      @(negedge clk);
      chk_b({p, "idle_busy"}, bus.busy, 1'b0);
   endtask

   function automatic logic [15:0] rnd_addr();
      logic [15:0] a;
      a = 16'($urandom_range(0, 7));
      a[15] = 1'($urandom_range(0, 1));
      return a;
   endfunction

   // Random traffic on both ports; completions are checked against model_mem.
   task automatic random_phase(input int n_cycles);
      logic        if_pend, mem_pend, mem_w;
      logic [15:0] if_a, mem_a, mem_d;
      int          if_age, mem_age;
      if_pend = 1'b0; mem_pend = 1'b0; mem_w = 1'b0;
      if_a = '0; mem_a = '0; mem_d = '0; if_age = 0; mem_age = 0;
      for (int c = 0; c < n_cycles + 40; c++) begin
         @(negedge clk);
         if (bus.if_valid) begin
            chk_b("rnd_if_valid_expected", bus.if_valid, if_pend);
            chk_w("rnd_if_instr", 18'(bus.if_instr), 18'(model_rd(if_a)));
            if_pend = 1'b0;
         end
         if (bus.mem_valid) begin
            chk_b("rnd_mem_valid_expected", bus.mem_valid, mem_pend);
            if (mem_w) begin
               chk_w("rnd_wr_rdata_hold", 18'(bus.mem_rdata), 18'(last_mem_rd));
               model_mem[mem_a] = mem_d;
            end else begin
               chk_w("rnd_mem_rdata", 18'(bus.mem_rdata), 18'(model_rd(mem_a)));
               last_mem_rd = model_rd(mem_a);
            end
            mem_pend = 1'b0;
         end
         if (if_pend) if_age++;
         if (mem_pend) mem_age++;
         if (if_age > 12 || mem_age > 12) begin
            n_vec++; n_err++;
            $display("FAIL rnd_timeout: if_age %0d mem_age %0d, limit 12", if_age, mem_age);
            break;
         end
         if (c >= n_cycles && !if_pend && !mem_pend) break;
         if (c < n_cycles && !if_pend && $urandom_range(0, 3) != 0) begin
            if_pend = 1'b1; if_age = 0; if_a = rnd_addr();
         end
         if (c < n_cycles && !mem_pend && $urandom_range(0, 3) != 0) begin
            mem_pend = 1'b1; mem_age = 0; mem_a = rnd_addr();
            mem_w = 1'($urandom_range(0, 1)); mem_d = 16'($urandom);
         end
         bus.if_req = if_pend;   bus.if_addr = if_a;
         bus.mem_req = mem_pend; bus.mem_addr = mem_a; bus.mem_we = mem_w; bus.mem_wdata = mem_d;
      end
      bus.if_req = 1'b0; bus.mem_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
      last_mem_rd = 16'h0000;
      for (int i = 0; i < 65536; i++) sram[i] = 16'(i) ^ 16'h5A5A;
      sram[16'h0010] = 16'hABCD;
      model_mem[16'h0010] = 16'hABCD;

      vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD};
      vecs[1] = '{1'b1, 1'b1, 16'h8000, 16'h1234, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h1234};
      vecs[3] = '{1'b0, 1'b0, 16'h8000, 16'h0000, 16'h1234};
      vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hABCD};
      vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
      vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0000};
      vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000};

      // Reset values
      repeat (2) @(negedge clk);
      chk_b("rst_en", ram2en, 1'b1);
      chk_b("rst_oe", ram2oe, 1'b1);
      chk_b("rst_we", ram2we, 1'b1);
      chk_w("rst_addr", ram2addr, 18'h0);
      chk_w("rst_if_instr", 18'(bus.if_instr), 18'h0800);
      chk_w("rst_mem_rdata", 18'(bus.mem_rdata), 18'h0);
      chk_b("rst_busy", bus.busy, 1'b0);
      chk_b("rst_valid", bus.if_valid | bus.mem_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset asserted mid-STROBE aborts the access with no valid pulse.
      bus.if_req = 1'b1; bus.if_addr = 16'h0010;
      @(negedge clk);
      @(negedge clk);
      chk_b("ar_strobe_oe", ram2oe, 1'b0);
      rst = 1'b1;
      bus.if_req = 1'b0;
      #1;
      chk_b("ar_en", ram2en, 1'b1);
      chk_b("ar_oe", ram2oe, 1'b1);
      chk_b("ar_we", ram2we, 1'b1);
      chk_b("ar_busy", bus.busy, 1'b0);
      chk_w("ar_if_instr", 18'(bus.if_instr), 18'h0800);
      chk_w("ar_mem_rdata", 18'(bus.mem_rdata), 18'h0);
      last_mem_rd = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_b("ar_no_valid", bus.if_valid | bus.mem_valid, 1'b0);
         chk_b("ar_idle_busy", bus.busy, 1'b0);
      end

      // Contention: mem served first, fetch follows back-to-back.
      tie_pair("tie1_", 16'h0020, 16'h0030, 1'b0);
      // Second tie: round-robin favours the previous loser.
`ifdef RAM2_RR_PRIORITY_EN
      tie_pair("tie2_", 16'h0040, 16'h0050, 1'b1);
`else
      tie_pair("tie2_", 16'h0040, 16'h0050, 1'b0);
`endif

      // Same port held high with a new address: old address must not be served twice.
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 16'h0060;
      repeat (3) @(negedge clk);
      chk_b("b2b_same_valid1", bus.mem_valid, 1'b1);
      chk_w("b2b_same_rd1", 18'(bus.mem_rdata), 18'(model_rd(16'h0060)));
      bus.mem_addr = 16'h0061;
      @(negedge clk);
      chk_b("b2b_same_idle_busy", bus.busy, 1'b0);
      chk_b("b2b_same_idle_en", ram2en, 1'b1);
      chk_b("b2b_same_idle_valid", bus.mem_valid, 1'b0);
      @(negedge clk);
      chk_w("b2b_same_setup_addr", ram2addr, 18'h00061);
      @(negedge clk);
      chk_b("b2b_same_strobe_valid", bus.mem_valid, 1'b0);
      @(negedge clk);
      chk_b("b2b_same_valid2", bus.mem_valid, 1'b1);
      chk_w("b2b_same_rd2", 18'(bus.mem_rdata), 18'(model_rd(16'h0061)));
      last_mem_rd = model_rd(16'h0061);
      bus.mem_req = 1'b0;
      @(negedge clk);

      random_phase(2000);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
